vga_rect_fill: RTL and testbench
================================

Name: vga_rect_fill

Overview:
- Framebuffer writer for the VGA display block: drives its wr_en/wr_addr/wr_data write port.
- Accepts rectangle-fill commands (origin, size, colour) over a valid/ready handshake.
- Clips each command to the visible area and streams one pixel write per clock, row-major, into linear address y*VGA_WIDTH + x.
- Sits between the control logic (switch/key handler or soft core) and the VGA block's write port, in the same clock domain as the VGA block.

Parameters:
- VGA_WIDTH, 640, visible pixels per line.
- VGA_HEIGHT, 480, visible lines.
- VGA_COLOR_DEPTH, 8, bits per colour channel.
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^ADDR_WIDTH >= VGA_WIDTH*VGA_HEIGHT.
- COORD_WIDTH, 10, width of coordinate and size fields.

Ports:
- clk  in  1  system clock, same clock as the VGA block.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  COORD_WIDTH  left column.
- cmd_y  in  COORD_WIDTH  top row.
- cmd_w  in  COORD_WIDTH  width in pixels.
- cmd_h  in  COORD_WIDTH  height in pixels.
- cmd_color  in  3*VGA_COLOR_DEPTH  fill colour, {R,G,B}, R in the MSBs.
- wr_en_o  out  1  framebuffer write strobe.
- wr_addr_o  out  ADDR_WIDTH  framebuffer write address.
- wr_data_o  out  3*VGA_COLOR_DEPTH  framebuffer write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Clock and reset: single clock. rst is synchronous, active-high, and dominates all other inputs.
- Reset values: cmd_ready=1, busy=0, done=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, FSM in IDLE.
- Reset while in SETUP or FILL: aborts the command. No further writes and no done pulse.
- FSM states: IDLE -> SETUP -> FILL -> DONE -> IDLE.
- Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. All cmd_* fields are registered at acceptance and may change afterwards.
- IDLE: on acceptance go to SETUP and set busy=1.
- SETUP, one cycle:
  - Clip: x_end = min(x+w, VGA_WIDTH) and y_end = min(y+h, VGA_HEIGHT), with sums computed at COORD_WIDTH+1 bits so there is no overflow.
  - Empty command: if w==0, h==0, x>=VGA_WIDTH or y>=VGA_HEIGHT, go to DONE with no writes.
  - Otherwise: row_base = y*VGA_WIDTH + x (ADDR_WIDTH bits), cur_x = x, cur_y = y, then go to FILL.
- FILL:
  - Every cycle: wr_en_o=1, wr_addr_o = row_base + (cur_x - x), wr_data_o = colour. There is no backpressure.
  - Increment cur_x. When cur_x reaches x_end-1: reset cur_x to x, add VGA_WIDTH to row_base, increment cur_y.
  - Go to DONE after the write at (x_end-1, y_end-1).
  - Exactly (x_end-x)*(y_end-y) writes occur on consecutive cycles, with strictly increasing addresses.
- DONE, one cycle: done=1, wr_en_o=0. Next state IDLE with busy=0 and cmd_ready=1. busy=1 in SETUP, FILL and DONE.
- Latency:
  - Command accepted at edge N: first wr_en_o at cycle N+2.
  - Last write at cycle N+1+P, where P is the clipped pixel count.
  - done at cycle N+2+P.
  - Empty command: done at cycle N+2.
- wr_addr_o and wr_data_o hold their last values while wr_en_o=0. They are don't-care for the VGA block.
- Back-to-back: a new command may be accepted in the cycle immediately after done.

Test Plan:
- Reset: assert rst for 3 cycles mid-FILL of a 10x10 command -> wr_en_o=0 from the next cycle, cmd_ready=1, no done pulse.
- Basic fill: x=2, y=1, w=3, h=2, colour=0xFF0000 -> 6 writes at addresses 642, 643, 644, 1282, 1283, 1284, all with data 0xFF0000, starting 2 cycles after acceptance; done 1 cycle after address 1284.
- Right/bottom clip: x=638, y=479, w=5, h=4 -> exactly 2 writes at 307198 and 307199; done follows.
- Empty commands: w=0; separately x=640 -> zero writes, done exactly 2 cycles after acceptance.
- Full screen: x=0, y=0, w=640, h=480 -> 307200 consecutive writes at addresses 0..307199, no gaps, busy high throughout.
- Handshake: hold cmd_valid high with two distinct commands queued by the bench -> second accepted only in the cycle after the first done; cmd_ready=0 while busy; no write from the second before its SETUP.

Source files
------------

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine for the VGA framebuffer write port.
// Clips each command to the visible area and emits one pixel write per clock, row-major.
module vga_rect_fill #(
  parameter int VGA_WIDTH       = 640,
  parameter int VGA_HEIGHT      = 480,
  parameter int VGA_COLOR_DEPTH = 8,
  parameter int ADDR_WIDTH      = 19,
  parameter int COORD_WIDTH     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [COORD_WIDTH-1:0]       cmd_x,
  input  logic [COORD_WIDTH-1:0]       cmd_y,
  input  logic [COORD_WIDTH-1:0]       cmd_w,
  input  logic [COORD_WIDTH-1:0]       cmd_h,
  input  logic [3*VGA_COLOR_DEPTH-1:0] cmd_color,
  output logic                         wr_en_o,
  output logic [ADDR_WIDTH-1:0]        wr_addr_o,
  output logic [3*VGA_COLOR_DEPTH-1:0] wr_data_o,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = 3 * VGA_COLOR_DEPTH;
  localparam logic [COORD_WIDTH:0]  WIDTH_LIM   = (COORD_WIDTH + 1)'(VGA_WIDTH);
  localparam logic [COORD_WIDTH:0]  HEIGHT_LIM  = (COORD_WIDTH + 1)'(VGA_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(VGA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t                  state_reg;
  logic [COORD_WIDTH-1:0]  x_reg, y_reg, w_reg, h_reg;
  logic [CW-1:0]           color_reg;
  logic [COORD_WIDTH:0]    x_last_reg, y_last_reg;
  logic [COORD_WIDTH:0]    cur_x_reg, cur_y_reg;
  logic [ADDR_WIDTH-1:0]   row_base_reg;

  logic [COORD_WIDTH:0]    x_sum, y_sum, x_end, y_end;
  logic                    empty_cmd;
  logic                    row_end, last_pixel;
  logic [ADDR_WIDTH-1:0]   setup_base, next_row_base;

  // Sums are one bit wider than the coordinates so x+w can never wrap.
  always_comb begin
    x_sum         = {1'b0, x_reg} + {1'b0, w_reg};
    y_sum         = {1'b0, y_reg} + {1'b0, h_reg};
    x_end         = (x_sum > WIDTH_LIM)  ? WIDTH_LIM  : x_sum;
    y_end         = (y_sum > HEIGHT_LIM) ? HEIGHT_LIM : y_sum;
    empty_cmd     = (w_reg == '0) || (h_reg == '0) ||
                    ({1'b0, x_reg} >= WIDTH_LIM) || ({1'b0, y_reg} >= HEIGHT_LIM);
    setup_base    = ADDR_WIDTH'(y_reg) * LINE_STRIDE + ADDR_WIDTH'(x_reg);
    next_row_base = row_base_reg + LINE_STRIDE;
    row_end       = (cur_x_reg == x_last_reg);
    last_pixel    = row_end && (cur_y_reg == y_last_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      x_last_reg   <= '0;
      y_last_reg   <= '0;
      cur_x_reg    <= '0;
      cur_y_reg    <= '0;
      row_base_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            x_reg     <= cmd_x;
            y_reg     <= cmd_y;
            w_reg     <= cmd_w;
            h_reg     <= cmd_h;
            color_reg <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (empty_cmd) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            x_last_reg   <= x_end - 1'b1;
            y_last_reg   <= y_end - 1'b1;
            cur_x_reg    <= {1'b0, x_reg};
            cur_y_reg    <= {1'b0, y_reg};
            row_base_reg <= setup_base;
            wr_en_o      <= 1'b1;
            wr_addr_o    <= setup_base;
            wr_data_o    <= color_reg;
            state_reg    <= FILL;
          end
        end
        FILL: begin
          // The registered outputs always describe the pixel at (cur_x, cur_y).
          if (last_pixel) begin
            wr_en_o   <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (row_end) begin
            cur_x_reg    <= {1'b0, x_reg};
            cur_y_reg    <= cur_y_reg + 1'b1;
            row_base_reg <= next_row_base;
            wr_addr_o    <= next_row_base;
          end else begin
            cur_x_reg <= cur_x_reg + 1'b1;
            wr_addr_o <= wr_addr_o + 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomised bench for vga_rect_fill: a pixel-list model predicts every write, done and busy cycle.
// Directed cases pin the model with hand-computed addresses and latencies.
module tb_vga_rect_fill;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic        wr_en_o;
  logic [18:0] wr_addr_o;
  logic [23:0] wr_data_o;
  logic        busy;
  logic        done;

  vga_rect_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: list of expected writes tagged with the cycle they must appear in.
  typedef struct {int c; int addr; int data;} wr_t;
  wr_t wq[$];
  int  done_cyc  = -1;
  int  busy_from = 0;
  int  busy_to   = -1;
  int  n_cmds    = 0;

  int log_addr[$];
  int log_data[$];
  int acc_log[$];
  int done_log[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit exp_wr;
      bit exp_busy;
      exp_wr   = (wq.size() > 0) && (wq[0].c == cyc);
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      chk("wr_en", int'(wr_en_o), int'(exp_wr));
      if (exp_wr) begin
        if (wr_en_o) begin
          chk("wr_addr", int'(wr_addr_o), wq[0].addr);
          chk("wr_data", int'(wr_data_o), wq[0].data);
        end
        void'(wq.pop_front());
      end
      chk("done", int'(done), int'(cyc == done_cyc));
      chk("busy", int'(busy), int'(exp_busy));
      chk("cmd_ready", int'(cmd_ready), int'(!exp_busy));
      if (wr_en_o) begin
        log_addr.push_back(int'(wr_addr_o));
        log_data.push_back(int'(wr_data_o));
      end
      if (done) done_log.push_back(cyc);
    end
    // Predict the effect of the coming clock edge.
    if (rst) begin
      wq.delete();
      done_cyc = -1;
      busy_from = 0;
      busy_to = -1;
    end else if (cmd_valid && cmd_ready) begin
      int a, xe, ye, p;
      a  = cyc + 1;
      xe = (int'(cmd_x) + int'(cmd_w) < W) ? int'(cmd_x) + int'(cmd_w) : W;
      ye = (int'(cmd_y) + int'(cmd_h) < H) ? int'(cmd_y) + int'(cmd_h) : H;
      p  = 0;
      for (int yy = int'(cmd_y); yy < ye; yy++)
        for (int xx = int'(cmd_x); xx < xe; xx++) begin
          wq.push_back('{c: a + 1 + p, addr: yy * W + xx, data: int'(cmd_color)});
          p++;
        end
      done_cyc  = a + 1 + p;
      busy_from = a;
      busy_to   = a + 1 + p;
      acc_log.push_back(a);
      n_cmds++;
      $display("cmd %0d at cycle %0d: x=%0d y=%0d w=%0d h=%0d color=%06h pixels=%0d",
               n_cmds, a, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, p);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command and returns #1 after the accepting edge, cmd_valid left high.
  task automatic send(input int x, input int y, input int w, input int h, input int color);
    bit got = 0;
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = 24'(color);
    cmd_valid = 1'b1;
    for (int k = 0; k < 50000; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    cmd_valid = 1'b0;
    cmd_x = 10'($urandom); cmd_y = 10'($urandom);
    cmd_w = 10'($urandom); cmd_h = 10'($urandom);
    cmd_color = 24'($urandom);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int k = 0; k < 50000; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
  endtask

  int exp_basic[6] = '{642, 643, 644, 1282, 1283, 1284};
  int a_first, d_first, n_done_before;

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_wr_en", int'(wr_en_o), 0);
    chk("reset_wr_addr", int'(wr_addr_o), 0);
    chk("reset_wr_data", int'(wr_data_o), 0);
    wait_cycles(1);

    // Basic fill
    clear_logs();
    send(2, 1, 3, 2, 24'hFF0000);
    drop_valid();
    wait_done();
    chk("basic_count", log_addr.size(), 6);
    for (int k = 0; k < 6 && k < log_addr.size(); k++) begin
      chk("basic_addr", log_addr[k], exp_basic[k]);
      chk("basic_data", log_data[k], 24'hFF0000);
    end
    chk("basic_done_latency", done_log[$] - acc_log[$], 7);

    // Right/bottom clip
    clear_logs();
    send(638, 479, 5, 4, 24'h00FF00);
    drop_valid();
    wait_done();
    chk("clip_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("clip_addr0", log_addr[0], 307198);
      chk("clip_addr1", log_addr[1], 307199);
    end
    chk("clip_done_latency", done_log[$] - acc_log[$], 3);

    // Empty commands
    clear_logs();
    send(10, 10, 0, 5, 24'h123456);
    drop_valid();
    wait_done();
    chk("empty_w_latency", done_log[$] - acc_log[$], 1);
    send(640, 10, 5, 5, 24'h123456);
    drop_valid();
    wait_done();
    chk("empty_x_latency", done_log[$] - acc_log[$], 1);
    chk("empty_writes", log_addr.size(), 0);

    // Full-width band clipped at the bottom edge
    clear_logs();
    send(0, 470, 640, 20, 24'h0000FF);
    drop_valid();
    wait_done();
    chk("band_count", log_addr.size(), 6400);
    if (log_addr.size() > 0) begin
      chk("band_first", log_addr[0], 300800);
      chk("band_last", log_addr[$], 307199);
    end

    // Two commands queued back-to-back with cmd_valid held high
    send(5, 5, 4, 3, 24'hABCDEF);
    a_first = acc_log[$];
    send(100, 200, 2, 2, 24'h345678);
    drop_valid();
    wait_done();
    d_first = done_log[$-1];
    chk("b2b_accept_gap", acc_log[$] - a_first, 15);
    chk("b2b_after_done", acc_log[$] - d_first, 2);

    // Reset in the middle of a 10x10 fill
    send(300, 100, 10, 10, 24'h777777);
    drop_valid();
    wait_cycles(40);
    n_done_before = done_log.size();
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(120);
    chk("abort_no_done", done_log.size(), n_done_before);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_wr_en", int'(wr_en_o), 0);

    // Start of a full-screen fill, aborted after many gap-free writes
    clear_logs();
    send(0, 0, 640, 480, 24'h5A5A5A);
    drop_valid();
    wait_cycles(20000);
    chk("fullscreen_progress", int'(log_addr.size() > 19990), 1);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);

    // Randomised commands, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 700), $urandom_range(0, 520),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
           int'($urandom & 32'hFFFFFF));
      if ($urandom_range(0, 1) == 1) begin
        drop_valid();
        wait_cycles($urandom_range(0, 5));
      end
    end
    drop_valid();
    wait_cycles(500);
    chk("model_drained", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
